adt7310_spi_responder: RTL and testbench

//  SPI slave that models the ADT7310 temperature sensor, driven by the on-chip SPI master.
//  It lets the sensor application and its SPI FSM be exercised in-system without the external part.

---
 rtl/adt7310_spi_responder_if.sv | 10 +
 rtl/adt7310_spi_responder.sv | 243 ++++++++++++++++++++++++
 tb/tb_adt7310_spi_responder.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/adt7310_spi_responder_if.sv
// SPI pin bundle between the on-chip SPI master and the ADT7310 responder model.
interface adt7310_spi_responder_if;
  logic SCK_i;
  logic MOSI_i;
  logic CS_n_i;
  logic MISO_o;

  modport master (output SCK_i, output MOSI_i, output CS_n_i, input MISO_o);
  modport slave  (input SCK_i, input MOSI_i, input CS_n_i, output MISO_o);
endinterface

// File: rtl/adt7310_spi_responder.sv
// ADT7310 temperature sensor model as an SPI mode-3 slave, oversampled in the Clk_i domain.
// Define ADT7310_CONT_READ_EN to enable continuous temperature reads (command bit2).
module adt7310_spi_responder #(
  parameter logic [7:0]  IDValue     = 8'hC3,
  parameter logic [7:0]  ConfigReset = 8'h00,
  parameter int unsigned SyncStages  = 2
) (
  input  logic                   Clk_i,
  input  logic                   Reset_n_i,
  adt7310_spi_responder_if.slave spi,
  input  logic [15:0]            TempValue_i,
  input  logic                   TempValid_i,
  output logic [7:0]             Config_o,
  output logic                   CmdStrobe_o,
  output logic                   TempRead_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_READ   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_IGNORE = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [SyncStages-1:0] sck_sync_q, sck_sync_d;
  logic [SyncStages-1:0] mosi_sync_q, mosi_sync_d;
  logic [SyncStages-1:0] cs_sync_q, cs_sync_d;
  logic                  sck_prev_q, sck_prev_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [6:0]            shift_q, shift_d;
  logic [2:0]            addr_q, addr_d;
  logic [15:0]           shadow_q, shadow_d;
  logic                  miso_q, miso_d;
  logic [7:0]            config_q, config_d;
  logic                  new_sample_q, new_sample_d;
  logic                  cmd_strobe_q, cmd_strobe_d;
  logic                  temp_read_q, temp_read_d;
`ifdef ADT7310_CONT_READ_EN
  logic                  cont_q, cont_d;
`endif

  logic       sck_s, mosi_s, cs_n_s;
  logic       sck_rise_s, sck_fall_s;
  logic       sample_clr_s;
  logic [3:0] last_bit_s;

  // Read data is MSB-aligned so 8-bit registers shift out of bit 15 like the temperature.
  function automatic logic [15:0] reg_value(input logic [2:0] a, input logic ns,
                                            input logic [7:0] cfg, input logic [15:0] temp);
    logic [15:0] v;
    case (a)
      3'd0:    v = {~ns, 15'd0};
      3'd1:    v = {cfg, 8'd0};
      3'd2:    v = temp;
      3'd3:    v = {IDValue, 8'd0};
      default: v = 16'd0;
    endcase
    return v;
  endfunction

  assign sck_s      = sck_sync_q[SyncStages-1];
  assign mosi_s     = mosi_sync_q[SyncStages-1];
  assign cs_n_s     = cs_sync_q[SyncStages-1];
  assign sck_rise_s = sck_s & ~sck_prev_q;
  assign sck_fall_s = ~sck_s & sck_prev_q;
  assign last_bit_s = (addr_q == 3'd2) ? 4'd15 : 4'd7;

  // Input synchronizers and SCK edge history.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SyncStages-2:0], spi.SCK_i};
    mosi_sync_d = {mosi_sync_q[SyncStages-2:0], spi.MOSI_i};
    cs_sync_d   = {cs_sync_q[SyncStages-2:0], spi.CS_n_i};
    sck_prev_d  = sck_s;
  end

  // Frame FSM: command decode, read shift-out and write shift-in.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    addr_d       = addr_q;
    shadow_d     = shadow_q;
    miso_d       = miso_q;
    config_d     = config_q;
    cmd_strobe_d = 1'b0;
    temp_read_d  = 1'b0;
    sample_clr_s = 1'b0;
`ifdef ADT7310_CONT_READ_EN
    cont_d       = cont_q;
`endif
    if (cs_n_s) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 4'd0;
      miso_d    = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d   = ST_CMD;
          bit_cnt_d = 4'd0;
        end
        ST_CMD: begin
          if (sck_rise_s) begin
            shift_d   = {shift_q[5:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              // shift_q holds command bits 7..1 here; bit0 is don't-care.
              cmd_strobe_d = 1'b1;
              bit_cnt_d    = 4'd0;
              addr_d       = shift_q[4:2];
              if (shift_q[6]) begin
                state_d = ST_IGNORE;
              end else if (shift_q[5]) begin
                state_d  = ST_READ;
                shadow_d = reg_value(shift_q[4:2], new_sample_q, config_q, TempValue_i);
`ifdef ADT7310_CONT_READ_EN
                cont_d   = shift_q[1];
`endif
              end else begin
                state_d = ST_WRITE;
              end
            end else begin
              cmd_strobe_d = 1'b0;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        ST_READ: begin
          if (sck_fall_s) begin
            miso_d   = shadow_q[15];
            shadow_d = {shadow_q[14:0], 1'b1};
          end else if (sck_rise_s) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == last_bit_s) begin
              if (addr_q == 3'd2) begin
                temp_read_d  = 1'b1;
                sample_clr_s = 1'b1;
              end else begin
                temp_read_d = 1'b0;
              end
`ifdef ADT7310_CONT_READ_EN
              if (cont_q && (addr_q == 3'd2)) begin
                shadow_d  = TempValue_i;
                bit_cnt_d = 4'd0;
              end else begin
                state_d = ST_IGNORE;
              end
`else
              state_d = ST_IGNORE;
`endif
            end else begin
              state_d = ST_READ;
            end
          end else begin
            shadow_d = shadow_q;
          end
        end
        ST_WRITE: begin
          if (sck_rise_s) begin
            shift_d   = {shift_q[5:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              state_d = ST_IGNORE;
              if (addr_q == 3'd1) begin
                config_d = {shift_q, mosi_s};
              end else begin
                config_d = config_q;
              end
            end else begin
              state_d = ST_WRITE;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        ST_IGNORE: begin
          miso_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          miso_d  = 1'b1;
        end
      endcase
    end
    // A fresh sample wins over the clear from a completed temperature read.
    if (TempValid_i) begin
      new_sample_d = 1'b1;
    end else if (sample_clr_s) begin
      new_sample_d = 1'b0;
    end else begin
      new_sample_d = new_sample_q;
    end
  end

  // State and output registers.
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state_q      <= ST_IDLE;
      sck_sync_q   <= {SyncStages{1'b1}};
      mosi_sync_q  <= {SyncStages{1'b0}};
      cs_sync_q    <= {SyncStages{1'b1}};
      sck_prev_q   <= 1'b1;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 7'd0;
      addr_q       <= 3'd0;
      shadow_q     <= 16'hFFFF;
      miso_q       <= 1'b1;
      config_q     <= ConfigReset;
      new_sample_q <= 1'b0;
      cmd_strobe_q <= 1'b0;
      temp_read_q  <= 1'b0;
`ifdef ADT7310_CONT_READ_EN
      cont_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sck_sync_q   <= sck_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      cs_sync_q    <= cs_sync_d;
      sck_prev_q   <= sck_prev_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      addr_q       <= addr_d;
      shadow_q     <= shadow_d;
      miso_q       <= miso_d;
      config_q     <= config_d;
      new_sample_q <= new_sample_d;
      cmd_strobe_q <= cmd_strobe_d;
      temp_read_q  <= temp_read_d;
`ifdef ADT7310_CONT_READ_EN
      cont_q       <= cont_d;
`endif
    end
  end

  assign spi.MISO_o  = miso_q;
  assign Config_o    = config_q;
  assign CmdStrobe_o = cmd_strobe_q;
  assign TempRead_o  = temp_read_q;

endmodule

// File: tb/tb_adt7310_spi_responder.sv
// Self-checking bench for adt7310_spi_responder: directed vector table, corner sequences, random frames vs a model.
module tb_adt7310_spi_responder;

  localparam int HALF = 5;

  typedef struct {
    string       name;
    logic [7:0]  cmd;
    int          nd;
    logic [15:0] data;
    logic [15:0] temp;
    logic        valid;
    logic [15:0] exp;
    int          ecs;
    int          etr;
    logic [7:0]  ecfg;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] temp_value = 16'h0000;
  logic        temp_valid = 1'b0;
  logic [7:0]  cfg;
  logic        cmd_strobe;
  logic        temp_read;
  int          checks = 0;
  int          errors = 0;
  int          cs_cnt = 0;
  int          tr_cnt = 0;
  logic [7:0]  m_cfg;
  logic        m_ns;
  vec_t        vecs[$];

  adt7310_spi_responder_if bus();

  adt7310_spi_responder dut (
    .Clk_i       (clk),
    .Reset_n_i   (rst_n),
    .spi         (bus),
    .TempValue_i (temp_value),
    .TempValid_i (temp_valid),
    .Config_o    (cfg),
    .CmdStrobe_o (cmd_strobe),
    .TempRead_o  (temp_read)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cmd_strobe) cs_cnt <= cs_cnt + 1;
    if (temp_read)  tr_cnt <= tr_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [7:0] cmd, input int nd,
                              input logic [15:0] data, input logic [15:0] temp, input logic valid,
                              input logic [15:0] exp, input int ecs, input int etr, input logic [7:0] ecfg);
    vec_t v;
    v.name = name; v.cmd = cmd; v.nd = nd; v.data = data; v.temp = temp;
    v.valid = valid; v.exp = exp; v.ecs = ecs; v.etr = etr; v.ecfg = ecfg;
    return v;
  endfunction

  task automatic pulse_valid();
    @(negedge clk) temp_valid = 1'b1;
    @(negedge clk) temp_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Mode-3 master: MOSI changes with the SCK fall, MISO is captured just before the SCK rise.
  task automatic spi_frame(input logic [63:0] tx, input int nbits, input int chg_bit,
                           input logic [15:0] chg_val, input logic valid_end, output logic [63:0] rx);
    rx = 64'd0;
    @(negedge clk) bus.CS_n_i = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) temp_value = chg_val;
      bus.SCK_i  = 1'b0;
      bus.MOSI_i = tx[nbits-1-i];
      repeat (HALF) @(negedge clk);
      rx[nbits-1-i] = bus.MISO_o;
      bus.SCK_i = 1'b1;
      if (valid_end && (i == nbits - 1)) begin
        repeat (2) @(negedge clk);
        temp_valid = 1'b1;
        @(negedge clk) temp_valid = 1'b0;
        repeat (HALF - 3) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    bus.CS_n_i = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Reference: what a master should see for a whole frame, from the register map rules.
  task automatic model_frame(input logic [63:0] tx, input int nbits,
                             output logic [63:0] exp, output int ecs, output int etr);
    logic [7:0] cmd;
    int nd, a, len, words, val;
    bit cont;
    exp = 64'd0;
    for (int i = 0; i < nbits; i++) exp[i] = 1'b1;
    ecs = 0;
    etr = 0;
    if (nbits >= 8) begin
      ecs  = 1;
      nd   = nbits - 8;
      cmd  = 8'(tx >> nd);
      a    = int'(cmd[5:3]);
      if (!cmd[7] && cmd[6]) begin
        case (a)
          0:       val = m_ns ? 0 : 128;
          1:       val = int'(m_cfg);
          2:       val = int'(temp_value);
          3:       val = 195;
          default: val = 0;
        endcase
        len  = (a == 2) ? 16 : 8;
        cont = 1'b0;
`ifdef ADT7310_CONT_READ_EN
        cont = cmd[2] && (a == 2);
`endif
        words = cont ? nd / len : ((nd >= len) ? 1 : 0);
        for (int j = 0; j < nd; j++)
          if (cont || j < len) exp[nd-1-j] = 1'(val >> (len - 1 - (j % len)));
        if (a == 2) begin
          etr = words;
          if (words > 0) m_ns = 1'b0;
        end
      end else if (!cmd[7] && !cmd[6] && a == 1 && nd >= 8) begin
        m_cfg = 8'(tx >> (nd - 8));
      end
    end
  endtask

  initial begin
    logic [63:0] tx, rx, exp, mask;
    int cs0, tr0, ecs, etr, nbits, nd;
    logic [7:0] cmd;
    vec_t v;

    bus.SCK_i = 1'b1;
    bus.MOSI_i = 1'b0;
    bus.CS_n_i = 1'b1;

    vecs.push_back(mk("t2_temp",  8'h50, 16, 16'h0000, 16'h0C80, 1'b0, 16'h0C80, 1, 1, 8'h00));
    vecs.push_back(mk("t3_wr",    8'h08,  8, 16'h00A5, 16'h0C80, 1'b0, 16'h00FF, 1, 0, 8'hA5));
    vecs.push_back(mk("t3_rd",    8'h48,  8, 16'h0000, 16'h0C80, 1'b0, 16'h00A5, 1, 0, 8'hA5));
    vecs.push_back(mk("t4_id",    8'h58,  8, 16'h0000, 16'h0C80, 1'b0, 16'h00C3, 1, 0, 8'hA5));
    vecs.push_back(mk("t4_new",   8'h40,  8, 16'h0000, 16'h0C80, 1'b1, 16'h0000, 1, 0, 8'hA5));
    vecs.push_back(mk("t4_clr",   8'h50, 16, 16'h0000, 16'h0C80, 1'b0, 16'h0C80, 1, 1, 8'hA5));
    vecs.push_back(mk("t4_old",   8'h40,  8, 16'h0000, 16'h0C80, 1'b0, 16'h0080, 1, 0, 8'hA5));
    vecs.push_back(mk("t5_part",  8'h08,  5, 16'h001F, 16'h0C80, 1'b0, 16'h001F, 1, 0, 8'hA5));
    vecs.push_back(mk("t5_rd",    8'h48,  8, 16'h0000, 16'h0C80, 1'b0, 16'h00A5, 1, 0, 8'hA5));
    vecs.push_back(mk("ign_b7",   8'hC8,  8, 16'h0000, 16'h0C80, 1'b0, 16'h00FF, 1, 0, 8'hA5));
    vecs.push_back(mk("wr_ro",    8'h18,  8, 16'h003C, 16'h0C80, 1'b0, 16'h00FF, 1, 0, 8'hA5));
    vecs.push_back(mk("extra",    8'h58, 12, 16'h0000, 16'h0C80, 1'b0, 16'h0C3F, 1, 0, 8'hA5));
    vecs.push_back(mk("addr5",    8'h68,  8, 16'h0000, 16'h0C80, 1'b0, 16'h0000, 1, 0, 8'hA5));
    vecs.push_back(mk("temp_neg", 8'h50, 16, 16'h0000, 16'hF380, 1'b0, 16'hF380, 1, 1, 8'hA5));

    // T1: outputs while reset is held
    repeat (4) @(negedge clk);
    check("rst_miso", 64'(bus.MISO_o), 64'd1);
    check("rst_cfg", 64'(cfg), 64'h00);
    check("rst_cmdstb", 64'(cmd_strobe), 64'd0);
    check("rst_tempread", 64'(temp_read), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    foreach (vecs[k]) begin
      v = vecs[k];
      temp_value = v.temp;
      if (v.valid) pulse_valid();
      cs0 = cs_cnt;
      tr0 = tr_cnt;
      mask = (64'd1 << v.nd) - 64'd1;
      tx = (64'(v.cmd) << v.nd) | (64'(v.data) & mask);
      spi_frame(tx, 8 + v.nd, -1, 16'h0000, 1'b0, rx);
      check({v.name, "_miso"}, rx, (64'hFF << v.nd) | 64'(v.exp));
      check({v.name, "_cmdstb"}, 64'(cs_cnt - cs0), 64'(v.ecs));
      check({v.name, "_tempread"}, 64'(tr_cnt - tr0), 64'(v.etr));
      check({v.name, "_cfg"}, 64'(cfg), 64'(v.ecfg));
    end

    // SCK/MOSI activity with CS_n high is ignored
    cs0 = cs_cnt;
    for (int i = 0; i < 16; i++) begin
      bus.SCK_i = 1'b0; bus.MOSI_i = 1'($urandom);
      repeat (HALF) @(negedge clk);
      bus.SCK_i = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    check("cs_high_stb", 64'(cs_cnt - cs0), 64'd0);
    check("cs_high_miso", 64'(bus.MISO_o), 64'd1);
    check("cs_high_cfg", 64'(cfg), 64'hA5);

    // TempValid on the same cycle as the read-completion clear: set wins
    temp_value = 16'h1234;
    spi_frame(64'h50_0000, 24, -1, 16'h0000, 1'b1, rx);
    check("setwin_temp", rx, 64'hFF_1234);
    spi_frame(64'h4000, 16, -1, 16'h0000, 1'b0, rx);
    check("setwin_status", rx, 64'hFF00);

    // Reset in the middle of a write frame
    @(negedge clk) bus.CS_n_i = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      bus.SCK_i = 1'b0; bus.MOSI_i = (i == 4);
      repeat (HALF) @(negedge clk);
      bus.SCK_i = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_miso", 64'(bus.MISO_o), 64'd1);
    check("midrst_cfg", 64'(cfg), 64'h00);
    check("midrst_pulses", 64'({cmd_strobe, temp_read}), 64'd0);
    bus.CS_n_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    spi_frame(64'h4000, 16, -1, 16'h0000, 1'b0, rx);
    check("midrst_status", rx, 64'hFF80);
    m_cfg = 8'h00;
    m_ns  = 1'b0;

    // Random frames against the reference model
    for (int n = 0; n < 60; n++) begin
      temp_value = 16'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        pulse_valid();
        m_ns = 1'b1;
      end
      cmd = {($urandom_range(0, 7) == 0), 1'($urandom), 3'($urandom), 1'($urandom), 2'($urandom)};
      if ($urandom_range(0, 7) == 0) begin
        nbits = $urandom_range(1, 7);
        tx = 64'(cmd) >> (8 - nbits);
      end else begin
        nd = $urandom_range(0, 40);
        nbits = 8 + nd;
        tx = (64'(cmd) << nd) | ({$urandom, $urandom} & ((64'd1 << nd) - 64'd1));
      end
      cs0 = cs_cnt;
      tr0 = tr_cnt;
      model_frame(tx, nbits, exp, ecs, etr);
      spi_frame(tx, nbits, -1, 16'h0000, 1'b0, rx);
      check($sformatf("rnd%0d_miso", n), rx, exp);
      check($sformatf("rnd%0d_cmdstb", n), 64'(cs_cnt - cs0), 64'(ecs));
      check($sformatf("rnd%0d_tempread", n), 64'(tr_cnt - tr0), 64'(etr));
      check($sformatf("rnd%0d_cfg", n), 64'(cfg), 64'(m_cfg));
    end

    // T6: continuous temperature read, value changes in the middle of word 1
    temp_value = 16'h0C80;
    tr0 = tr_cnt;
    spi_frame(64'h54 << 48, 56, 16, 16'h0D00, 1'b0, rx);
`ifdef ADT7310_CONT_READ_EN
    check("cont_miso", rx, 64'h00FF_0C80_0D00_0D00);
    check("cont_tempread", 64'(tr_cnt - tr0), 64'd3);
`else
    check("cont_miso", rx, 64'h00FF_0C80_FFFF_FFFF);
    check("cont_tempread", 64'(tr_cnt - tr0), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
